regfile_multiport: RTL and testbench

Parametrised register file: the next generation of the 64-bit, 32-entry read-mux register file in the pipelined ARM datapath. It stores DEPTH registers of WIDTH bits, accepts one synchronous write per cycle, and serves NUM_RD independent combinational read ports. Same-cycle write-to-read bypass and an optional hardwired zero register (XZR) are built in. It sits in the decode stage; write port driven from writeback, read ports feed the decode/execute pipeline register.

---
 rtl/regfile_multiport.sv | 85 ++++++++
 tb/tb_regfile_multiport.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Multi-port register file: one synchronous write port, NUM_RD combinational read ports,
// same-cycle write-to-read bypass and an optional hardwired zero register at DEPTH-1.
module regfile_multiport #(
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      RegWrite,
  input  logic [ADDR_W-1:0]         WriteRegister,
  input  logic [WIDTH-1:0]          WriteData,
  input  logic [NUM_RD*ADDR_W-1:0]  ReadRegister,
  output logic [NUM_RD*WIDTH-1:0]   ReadData
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] XZR_ADDR = '1;
  localparam bit                HAS_XZR  = (ZERO_REG != 0);
  localparam bit                HAS_BYP  = (BYPASS != 0);

  if (ADDR_W < 1) begin : g_bad_addr_w
    $error("regfile_multiport: ADDR_W must be >= 1 so that DEPTH >= 2");
  end
  if (NUM_RD < 1) begin : g_bad_num_rd
    $error("regfile_multiport: NUM_RD must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("regfile_multiport: WIDTH must be >= 1");
  end

  logic [WIDTH-1:0] regs [DEPTH];
  logic             write_zero;
  logic             wr_en;

  // Writes aimed at the zero register are dropped before they reach storage.
  assign write_zero = HAS_XZR && (WriteRegister == XZR_ADDR);
  assign wr_en      = RegWrite && !write_zero;

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    logic entry_we;
    assign entry_we = wr_en && (WriteRegister == ADDR_W'(e));

    // NOTE: every entry is reset here because the register file must read back
    // zero after reset; an unreset RAM macro would expose power-up garbage.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        regs[e] <= '0;
      end else if (entry_we) begin
        // NOTE: state updates use non-blocking assignment so all flops sample
        // pre-edge values and simulation matches the synthesized hardware.
        regs[e] <= WriteData;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_read
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  rd_data;
    logic              is_zero;
    logic              byp_hit;

    assign addr    = ReadRegister[p*ADDR_W +: ADDR_W];
    assign is_zero = HAS_XZR && (addr == XZR_ADDR);
    assign byp_hit = HAS_BYP && RegWrite && !reset && (WriteRegister == addr);

    // Priority: reset, zero register, bypass, stored value.
    always_comb begin
      // NOTE: the default assignment first keeps this block free of inferred latches.
      rd_data = '0;
      if (reset || is_zero) begin
        rd_data = '0;
      end else if (byp_hit) begin
        rd_data = WriteData;
      end else begin
        rd_data = regs[addr];
      end
    end

    assign ReadData[p*WIDTH +: WIDTH] = rd_data;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: three instances cover the bypass/XZR default,
// the no-bypass variant, and a narrow register file without a zero register.
module tb_regfile_multiport;

  logic         clk;
  logic         reset;
  logic         we;
  logic [4:0]   waddr;
  logic [63:0]  wdata;
  logic [14:0]  raddr;
  logic [191:0] rd_a;
  logic [127:0] rd_b;

  logic         c_we;
  logic [2:0]   c_waddr;
  logic [31:0]  c_wdata;
  logic [2:0]   c_raddr;
  logic [31:0]  c_rd;

  int checks   = 0;
  int failures = 0;

  regfile_multiport #(.WIDTH(64), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .RegWrite(we), .WriteRegister(waddr), .WriteData(wdata),
    .ReadRegister(raddr), .ReadData(rd_a)
  );

  regfile_multiport #(.WIDTH(64), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .RegWrite(we), .WriteRegister(waddr), .WriteData(wdata),
    .ReadRegister(raddr[9:0]), .ReadData(rd_b)
  );

  regfile_multiport #(.WIDTH(32), .ADDR_W(3), .NUM_RD(1), .ZERO_REG(0), .BYPASS(1)) dut_c (
    .clk(clk), .reset(reset), .RegWrite(c_we), .WriteRegister(c_waddr), .WriteData(c_wdata),
    .ReadRegister(c_raddr), .ReadData(c_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  r0, r1, r2;
    logic [63:0] ea0, ea1, ea2;
    logic [63:0] eb0, eb1;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [63:0] val(int i);
    logic [31:0] hi;
    hi = i;
    return {hi, 32'hA5A5_0000 + hi};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rda(int p);
    return rd_a[p*64 +: 64];
  endfunction

  function automatic logic [63:0] rdb(int p);
    return rd_b[p*64 +: 64];
  endfunction

  initial begin
    logic [63:0] e0, e1;
    int j;

    vecs[0] = '{1'b1, 5'd7,  64'h1234, 5'd7,  5'd8,  5'd7,  64'h1234, val(8), 64'h1234, val(7), val(8)};
    vecs[1] = '{1'b0, 5'd0,  64'h0,    5'd7,  5'd7,  5'd8,  64'h1234, 64'h1234, val(8), 64'h1234, 64'h1234};
    vecs[2] = '{1'b1, 5'd31, '1,       5'd31, 5'd31, 5'd31, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    vecs[3] = '{1'b0, 5'd0,  64'h0,    5'd31, 5'd0,  5'd30, 64'h0, val(0), val(30), 64'h0, val(0)};
    vecs[4] = '{1'b1, 5'd12, 64'h55,   5'd12, 5'd12, 5'd12, 64'h55, 64'h55, 64'h55, val(12), val(12)};
    vecs[5] = '{1'b0, 5'd12, 64'hFF,   5'd12, 5'd12, 5'd12, 64'h55, 64'h55, 64'h55, 64'h55, 64'h55};
    vecs[6] = '{1'b1, 5'd12, 64'h66,   5'd12, 5'd13, 5'd12, 64'h66, val(13), 64'h66, 64'h55, val(13)};
    vecs[7] = '{1'b1, 5'd12, 64'h77,   5'd12, 5'd12, 5'd12, 64'h77, 64'h77, 64'h77, 64'h66, 64'h66};
    vecs[8] = '{1'b0, 5'd0,  64'h0,    5'd12, 5'd12, 5'd12, 64'h77, 64'h77, 64'h77, 64'h77, 64'h77};

    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    c_we = 1'b0; c_waddr = '0; c_wdata = '0; c_raddr = '0;

    #2;
    check("rst_a0", rda(0), 64'h0);
    check("rst_b0", rdb(0), 64'h0);

    // Bypass must be suppressed while reset is high.
    we = 1'b1; waddr = 5'd3; wdata = 64'h77; raddr = {5'd3, 5'd3, 5'd3};
    #1;
    check("rst_nobyp_a0", rda(0), 64'h0);
    check("rst_nobyp_a2", rda(2), 64'h0);
    tick();
    we = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("rst_nowrite_a0", rda(0), 64'h0);
    check("rst_nowrite_b0", rdb(0), 64'h0);

    // Write X5, then assert reset asynchronously between edges.
    we = 1'b1; waddr = 5'd5; wdata = 64'hDEADBEEF_CAFEF00D; raddr = {5'd5, 5'd5, 5'd5};
    tick();
    we = 1'b0;
    #1;
    check("x5_written_a0", rda(0), 64'hDEADBEEF_CAFEF00D);
    check("x5_written_b0", rdb(0), 64'hDEADBEEF_CAFEF00D);
    #1 reset = 1'b1;
    #1;
    check("async_rst_a0", rda(0), 64'h0);
    check("async_rst_b0", rdb(0), 64'h0);
    we = 1'b1; waddr = 5'd6; wdata = 64'h99;
    tick();
    we = 1'b0;
    #1 reset = 1'b0;
    raddr = {5'd6, 5'd6, 5'd5};
    #1;
    check("post_rst_x5_a", rda(0), 64'h0);
    check("post_rst_x6_a", rda(1), 64'h0);
    check("post_rst_x5_b", rdb(0), 64'h0);
    check("post_rst_x6_b", rdb(1), 64'h0);

    // Fill X0..X30, attempt an all-ones write to X31.
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i);
      wdata = (i == 31) ? '1 : val(i);
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      j = 31 - i;
      raddr = {5'(i), 5'(j), 5'(i)};
      #1;
      e0 = (i == 31) ? 64'h0 : val(i);
      e1 = (j == 31) ? 64'h0 : val(j);
      check($sformatf("fill_a0_x%0d", i), rda(0), e0);
      check($sformatf("fill_a1_x%0d", j), rda(1), e1);
      check($sformatf("fill_a2_x%0d", i), rda(2), e0);
      check($sformatf("fill_b0_x%0d", i), rdb(0), e0);
      check($sformatf("fill_b1_x%0d", j), rdb(1), e1);
    end

    // Bypass, XZR, aliasing and back-to-back vectors; one edge between vectors.
    for (int k = 0; k < 9; k++) begin
      we = vecs[k].we; waddr = vecs[k].wa; wdata = vecs[k].wd;
      raddr = {vecs[k].r2, vecs[k].r1, vecs[k].r0};
      #1;
      check($sformatf("vec%0d_a0", k), rda(0), vecs[k].ea0);
      check($sformatf("vec%0d_a1", k), rda(1), vecs[k].ea1);
      check($sformatf("vec%0d_a2", k), rda(2), vecs[k].ea2);
      check($sformatf("vec%0d_b0", k), rdb(0), vecs[k].eb0);
      check($sformatf("vec%0d_b1", k), rdb(1), vecs[k].eb1);
      tick();
    end
    we = 1'b0;

    // Narrow variant without a zero register: address 7 is an ordinary entry.
    c_we = 1'b1; c_waddr = 3'd0; c_wdata = 32'h0000_1111; c_raddr = 3'd7;
    tick();
    c_waddr = 3'd7; c_wdata = 32'hFFFF_FFFF;
    #1;
    check("c_byp_x7", {32'h0, c_rd}, 64'hFFFF_FFFF);
    tick();
    c_we = 1'b0; c_wdata = 32'h0;
    #1;
    check("c_x7", {32'h0, c_rd}, 64'hFFFF_FFFF);
    c_raddr = 3'd0;
    #1;
    check("c_x0_noalias", {32'h0, c_rd}, 64'h0000_1111);
    c_raddr = 3'd1;
    #1;
    check("c_x1_zero", {32'h0, c_rd}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
